// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake into a small FIFO, then one
// start bit, DATA_BITS data bits (LSB first) and one stop bit on tx.
// Optional even parity bit between data and stop: define UART_TX_PARITY_EN.
// rst_n is expected to be released synchronously by the board reset logic.
module uart_tx #(
    parameter int unsigned CLK_DIV    = 10417,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int unsigned TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic fifo_empty;
    logic bit_end;

    // FIFO status; a full FIFO refuses writes even when a pop is pending
    always_comb begin
        o_ready    = (count_q != CW'(FIFO_DEPTH));
        push       = i_valid && o_ready;
        fifo_empty = (count_q == CW'(0));
        bit_end    = (timer_q == TW'(CLK_DIV - 1));
    end

    // Next-state logic for the frame FSM, bit timer and FIFO pointers
    always_comb begin
        state_d  = state_q;
        timer_d  = bit_end ? TW'(0) : TW'(timer_q + TW'(1));
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                timer_d = TW'(0);
                pop     = !fifo_empty;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = IW'(idx_q + IW'(1));
                        tx_d    = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    pop     = !fifo_empty;
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Loading a new word starts a frame from either IDLE or the end of STOP
        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            idx_d    = IW'(0);
            timer_d  = TW'(0);
            state_d  = S_START;
            tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end

        wr_ptr_d = push ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? PW'(rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase

        busy_d = (state_q != S_IDLE) || !fifo_empty;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign tx        = tx_q;
    assign o_busy    = busy_q;
    assign o_tx_done = done_q;

endmodule
